// File: rtl/debug_pkg.sv
// Shared constants for the debug unit: state encodings, command bytes and snapshot size.
package debug_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_RUN       = 3'd1;
  localparam state_t ST_STEP      = 3'd2;
  localparam state_t ST_SEND      = 3'd3;
  localparam state_t ST_WAIT_SEND = 3'd4;
  localparam state_t ST_FLUSH     = 3'd5;

  localparam logic [7:0] CMD_RUN   = 8'h63;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_DUMP  = 8'h64;
  localparam logic [7:0] CMD_RESET = 8'h72;

  localparam int unsigned SNAP_BYTES = 324;
  localparam int unsigned SNAP_BITS  = SNAP_BYTES * 8;

endpackage

// File: rtl/debug_run_ctrl_if.sv
// Command/status bundle between the UART RX, pipeline and snapshot sender and debug_run_ctrl.
interface debug_run_ctrl_if;
  logic [7:0]  i_rx_data;
  logic        is_rx_done;
  logic        is_halt;
  logic        is_send_done;
  logic        os_pipe_en;
  logic        os_pipe_rst;
  logic        os_send_start;
  logic        os_busy;
  logic [31:0] o_cycle_count;
  logic [2:0]  o_state;

  modport slave (
    input  i_rx_data, is_rx_done, is_halt, is_send_done,
    output os_pipe_en, os_pipe_rst, os_send_start, os_busy, o_cycle_count, o_state
  );

  modport master (
    output i_rx_data, is_rx_done, is_halt, is_send_done,
    input  os_pipe_en, os_pipe_rst, os_send_start, os_busy, o_cycle_count, o_state
  );
endinterface

// File: rtl/debug_cycle_counter.sv
// 32-bit saturating counter of pipeline-enabled cycles, with synchronous clear.
module debug_cycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q, cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = 32'd0;
    else if (en_i) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 32'd0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/debug_run_ctrl.sv
// Debug command sequencer: run/step/dump/reset over UART, snapshot send after every stop.
// Optional RUN watchdog compiled in with `define DBG_WATCHDOG_EN.
module debug_run_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned RUN_MAX_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  debug_run_ctrl_if.slave  bus
);

  if (RUN_MAX_CYCLES < 2 || RUN_MAX_CYCLES > 65536) begin : g_bad_run_max
    $error("RUN_MAX_CYCLES out of range 2..65536");
  end

  state_t state_q, state_d;
  logic   pipe_en;
  logic   wd_exit;

`ifdef DBG_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(RUN_MAX_CYCLES - 1);
  logic [15:0] wd_q;

  // Held at zero outside RUN so every RUN entry starts counting from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wd_q <= 16'd0;
    else if (state_q != ST_RUN) wd_q <= 16'd0;
    else                        wd_q <= wd_q + 16'd1;
  end

  assign wd_exit = (wd_q == WD_LAST);
`else
  assign wd_exit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.is_rx_done) begin
          case (bus.i_rx_data)
            CMD_RUN:   state_d = bus.is_halt ? ST_SEND : ST_RUN;
            CMD_STEP:  state_d = bus.is_halt ? ST_SEND : ST_STEP;
            CMD_DUMP:  state_d = ST_SEND;
            CMD_RESET: state_d = ST_FLUSH;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (bus.is_halt || bus.is_rx_done || wd_exit) state_d = ST_SEND;
      end
      ST_STEP:      state_d = ST_SEND;
      ST_SEND:      state_d = ST_WAIT_SEND;
      ST_WAIT_SEND: if (bus.is_send_done) state_d = ST_IDLE;
      ST_FLUSH:     state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign pipe_en = (state_q == ST_RUN) || (state_q == ST_STEP);

  debug_cycle_counter u_cycle_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_FLUSH),
    .en_i  (pipe_en),
    .cnt_o (bus.o_cycle_count)
  );

  assign bus.os_pipe_en    = pipe_en;
  assign bus.os_pipe_rst   = (state_q == ST_FLUSH);
  assign bus.os_send_start = (state_q == ST_SEND);
  assign bus.os_busy       = (state_q != ST_IDLE);
  assign bus.o_state       = state_q;

endmodule
